// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART arbiter state encoding and timing constants
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_START,
      ST_WAIT_END,
      ST_DONE
   } arb_state_t;

   localparam int DEFAULT_BAUD        = 115200;
   localparam int OVERSAMPLE          = 8;
   localparam int START_TIMEOUT_BITS  = 5;
   localparam int DEFAULT_TIMEOUT_CYC = OVERSAMPLE * START_TIMEOUT_BITS;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [IDX_W-1:0]   o_winner,
   output logic               o_valid
);

   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = '0;
      // Scan farthest-first so the index just after i_last has the final say.
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between byte producers
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic                      bclk_x8,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic [NUM_REQ-1:0]        o_done,
   output logic                      o_tx_err,
   output logic                      o_tx_ready,
   output logic [DATA_W-1:0]         o_tx_byte,
   input  logic                      i_tx_status,
   output logic                      o_busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   arb_state_t               r_state;
   logic [NUM_REQ-1:0]       r_grant;
   logic [NUM_REQ-1:0]       r_done;
   logic                     r_tx_err;
   logic                     r_tx_ready;
   logic [DATA_W-1:0]        r_tx_byte;
   logic                     r_busy;
   logic                     r_err;
   logic [IDX_W-1:0]         r_last;
   logic [CNT_W-1:0]         r_cnt;
   logic [SYNC_STAGES-1:0]   r_ts_sync;
   logic [SYNC_STAGES-1:0]   r_primed;

   logic                     w_ts_s;
   logic [IDX_W-1:0]         w_winner;
   logic                     w_valid;
   logic [NUM_REQ-1:0]       w_onehot;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_req    (i_req),
      .i_last   (r_last),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_ts_s   = r_ts_sync[SYNC_STAGES-1];
   assign w_onehot = NUM_REQ'(1) << w_winner;

   // r_primed fills alongside the chain, so granting waits until ts_s holds a real sample after reset.
   always_ff @(posedge bclk_x8 or posedge rst) begin
      if (rst) begin
         r_ts_sync <= '0;
         r_primed  <= '0;
      end else begin
         r_ts_sync <= {r_ts_sync[SYNC_STAGES-2:0], i_tx_status};
         r_primed  <= {r_primed[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge bclk_x8 or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_done     <= '0;
         r_tx_err   <= 1'b0;
         r_tx_ready <= 1'b0;
         r_tx_byte  <= '0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_last     <= IDX_W'(NUM_REQ - 1);
         r_cnt      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid && !w_ts_s && r_primed[SYNC_STAGES-1]) begin
                  r_grant    <= w_onehot;
                  r_tx_byte  <= i_req_data[int'(w_winner)*DATA_W +: DATA_W];
                  r_tx_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_last     <= w_winner;
                  r_state    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               // Ready must fall once the frame starts, or it retriggers after the stop bit.
               if (w_ts_s) begin
                  r_tx_ready <= 1'b0;
                  r_state    <= ST_WAIT_END;
               end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  r_tx_ready <= 1'b0;
                  r_err      <= 1'b1;
                  r_done     <= r_grant;
                  r_tx_err   <= 1'b1;
                  r_state    <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT_END: begin
               if (!w_ts_s) begin
                  r_done   <= r_grant;
                  r_tx_err <= r_err;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done   <= '0;
               r_tx_err <= 1'b0;
               r_grant  <= '0;
               r_err    <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant    = r_grant;
   assign o_done     = r_done;
   assign o_tx_err   = r_tx_err;
   assign o_tx_ready = r_tx_ready;
   assign o_tx_byte  = r_tx_byte;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 40;

   logic        bclk_x8 = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  i_req = '0;
   logic [31:0] i_req_data = '0;
   logic        i_tx_status = 1'b0;
   logic [3:0]  o_grant, o_done;
   logic        o_tx_err, o_tx_ready, o_busy;
   logic [7:0]  o_tx_byte;

   int tests = 0;
   int fails = 0;

   int tm_ph = 0, tm_c = 0, tm_delay = 16, tm_hold = 80;
   bit tm_tied0 = 1'b0;
   int done_pulses = 0;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .bclk_x8     (bclk_x8),
      .rst         (rst),
      .i_req       (i_req),
      .i_req_data  (i_req_data),
      .o_grant     (o_grant),
      .o_done      (o_done),
      .o_tx_err    (o_tx_err),
      .o_tx_ready  (o_tx_ready),
      .o_tx_byte   (o_tx_byte),
      .i_tx_status (i_tx_status),
      .o_busy      (o_busy)
   );

   always #5 bclk_x8 = ~bclk_x8;

   // One negedge step: outputs are already sampled, then the transmitter model reacts.
   task automatic tick();
      @(negedge bclk_x8);
      if (o_done != 4'b0) done_pulses++;
      if (tm_tied0) begin
         i_tx_status = 1'b0;
      end else begin
         case (tm_ph)
            0: if (o_tx_ready) begin tm_ph = 1; tm_c = tm_delay; end
            1: begin tm_c--; if (tm_c == 0) begin i_tx_status = 1'b1; tm_ph = 2; tm_c = tm_hold; end end
            default: begin tm_c--; if (tm_c == 0) begin i_tx_status = 1'b0; tm_ph = 0; end end
         endcase
      end
   endtask

   task automatic wait_grant(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (o_grant != 4'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (o_done != 4'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; i_req = '0; i_tx_status = 1'b0;
      tm_ph = 0; tm_c = 0; tm_tied0 = 1'b0; tm_delay = 16; tm_hold = 80;
      tick(); tick();
      rst = 1'b0;
      repeat (3) tick();
   endtask

   function automatic int rr_model(input logic [3:0] r, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int i;
         i = (last + k) % NUM_REQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tests++;
      if ({o_grant, o_done, o_tx_err, o_tx_ready, o_tx_byte} !== 18'h0) begin
         fails++;
         $display("FAIL reset_outputs: grant=%b done=%b err=%b ready=%b byte=%h, required all 0", o_grant, o_done, o_tx_err, o_tx_ready, o_tx_byte);
      end
      tests++;
      if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", o_busy); end
   endtask

   task automatic test_single();
      int t_rise, t_drop, d0;
      bit regrant;
      do_reset();
      i_req_data = 32'h0000_00A5;
      i_req = 4'b0001;
      tick();
      tests++;
      if (o_grant !== 4'b0001 || o_tx_ready !== 1'b1) begin
         fails++; $display("FAIL single_grant: grant=%b ready=%b, required 0001/1", o_grant, o_tx_ready);
      end
      tests++;
      if (o_tx_byte !== 8'hA5) begin fails++; $display("FAIL single_byte: got %h required a5", o_tx_byte); end
      t_rise = -1; t_drop = -1; d0 = done_pulses; regrant = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (t_rise >= 0 && t_drop < 0 && !o_tx_ready) t_drop = i;
         if (t_rise < 0 && i_tx_status) t_rise = i;
         if (i_req == 4'b0 && o_grant != 4'b0 && o_done == 4'b0) regrant = 1'b1;
         if (o_done != 4'b0) begin
            tests++;
            if (o_done !== 4'b0001 || o_tx_err !== 1'b0) begin
               fails++; $display("FAIL single_done: done=%b err=%b required 0001/0", o_done, o_tx_err);
            end
            i_req = 4'b0;
         end
      end
      tests++;
      if (t_rise < 0 || t_drop <= t_rise || t_drop - t_rise > SYNC_STAGES + 1) begin
         fails++; $display("FAIL single_ready_drop: rise=%0d drop=%0d, required drop within %0d", t_rise, t_drop, SYNC_STAGES + 1);
      end
      tests++;
      if (done_pulses - d0 != 1 || regrant) begin
         fails++; $display("FAIL single_done_count: pulses=%0d regrant=%b required 1/0", done_pulses - d0, regrant);
      end
   endtask

   task automatic test_all_four();
      bit ok;
      int d0, e;
      do_reset();
      i_req_data = 32'h4433_2211;
      i_req = 4'b1111;
      d0 = done_pulses;
      for (int f = 0; f < 5; f++) begin
         e = f % NUM_REQ;
         wait_grant(100, ok);
         tests++;
         if (!ok || o_grant !== 4'(1 << e) || o_tx_byte !== 8'((e + 1) * 17)) begin
            fails++; $display("FAIL all4_grant%0d: grant=%b byte=%h required %b/%h", f, o_grant, o_tx_byte, 4'(1 << e), 8'((e + 1) * 17));
         end
         if (f == 4) i_req = 4'b0;
         wait_done(300, ok);
         tests++;
         if (!ok || o_done !== 4'(1 << e)) begin
            fails++; $display("FAIL all4_done%0d: done=%b required %b", f, o_done, 4'(1 << e));
         end
      end
      repeat (5) tick();
      tests++;
      if (done_pulses - d0 != 5) begin fails++; $display("FAIL all4_done_count: got %0d required 5", done_pulses - d0); end
   endtask

   task automatic test_fairness();
      bit ok;
      do_reset();
      i_req_data = $urandom;
      i_req = 4'b0010;
      wait_grant(50, ok);
      tests++;
      if (!ok || o_grant !== 4'b0010) begin fails++; $display("FAIL fair_first: got %b required 0010", o_grant); end
      i_req = 4'b1010;
      wait_done(300, ok);
      wait_grant(50, ok);
      tests++;
      if (!ok || o_grant !== 4'b1000) begin fails++; $display("FAIL fair_second: got %b required 1000", o_grant); end
      wait_done(300, ok);
      wait_grant(50, ok);
      tests++;
      if (!ok || o_grant !== 4'b0010) begin fails++; $display("FAIL fair_third: got %b required 0010", o_grant); end
      i_req = 4'b0;
      wait_done(300, ok);
   endtask

   task automatic test_timeout();
      int hi;
      do_reset();
      tm_tied0 = 1'b1;
      i_req_data = 32'h00C3_0000;
      i_req = 4'b0100;
      tick();
      tests++;
      if (o_grant !== 4'b0100 || o_tx_ready !== 1'b1 || o_tx_byte !== 8'hC3) begin
         fails++; $display("FAIL to_grant: grant=%b ready=%b byte=%h required 0100/1/c3", o_grant, o_tx_ready, o_tx_byte);
      end
      hi = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_tx_ready) hi++; else break;
      end
      tests++;
      if (hi != TIMEOUT_CYC + 1) begin fails++; $display("FAIL to_ready_len: got %0d cycles required %0d", hi, TIMEOUT_CYC + 1); end
      tests++;
      if (o_done !== 4'b0100 || o_tx_err !== 1'b1) begin
         fails++; $display("FAIL to_done_err: done=%b err=%b required 0100/1", o_done, o_tx_err);
      end
      i_req = 4'b0;
      tick();
      tests++;
      if (o_grant !== 4'b0 || o_done !== 4'b0 || o_tx_err !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL to_idle: grant=%b done=%b err=%b busy=%b required all 0", o_grant, o_done, o_tx_err, o_busy);
      end
      tm_tied0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok, early;
      do_reset();
      i_req_data = 32'h0000_005A;
      i_req = 4'b0001;
      for (int i = 0; i < 100; i++) begin tick(); if (i_tx_status) break; end
      repeat (5) tick();
      tests++;
      if (o_busy !== 1'b1 || o_tx_ready !== 1'b0 || o_grant !== 4'b0001) begin
         fails++; $display("FAIL rmid_wait_end: busy=%b ready=%b grant=%b required 1/0/0001", o_busy, o_tx_ready, o_grant);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({o_grant, o_done, o_tx_err, o_tx_ready, o_tx_byte, o_busy} !== 19'h0) begin
         fails++; $display("FAIL rmid_async: grant=%b done=%b err=%b ready=%b byte=%h busy=%b required 0", o_grant, o_done, o_tx_err, o_tx_ready, o_tx_byte, o_busy);
      end
      tick(); tick();
      rst = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 200 && i_tx_status; i++) begin
         tick();
         if (o_grant != 4'b0) early = 1'b1;
      end
      tick(); if (o_grant != 4'b0) early = 1'b1;
      tick(); if (o_grant != 4'b0) early = 1'b1;
      tests++;
      if (early || i_tx_status) begin fails++; $display("FAIL rmid_no_grant: early=%b status=%b required 0/0", early, i_tx_status); end
      tick();
      tests++;
      if (o_grant !== 4'b0001) begin fails++; $display("FAIL rmid_regrant: got %b required 0001", o_grant); end
      i_req = 4'b0;
      wait_done(300, ok);
      tests++;
      if (!ok || o_done !== 4'b0001) begin fails++; $display("FAIL rmid_done: done=%b required 0001", o_done); end
   endtask

   task automatic test_req_drop();
      bit ok, stray;
      do_reset();
      i_req_data = 32'h0000_0077;
      i_req = 4'b0001;
      wait_grant(50, ok);
      repeat (3) tick();
      tests++;
      if (!ok || o_tx_ready !== 1'b1 || o_busy !== 1'b1) begin
         fails++; $display("FAIL drop_wait_start: ready=%b busy=%b required 1/1", o_tx_ready, o_busy);
      end
      i_req = 4'b0;
      wait_done(300, ok);
      tests++;
      if (!ok || o_done !== 4'b0001) begin fails++; $display("FAIL drop_done: done=%b required 0001", o_done); end
      tick();
      stray = 1'b0;
      for (int i = 0; i < 30; i++) begin tick(); if (o_grant != 4'b0) stray = 1'b1; end
      tests++;
      if (stray) begin fails++; $display("FAIL drop_no_regrant: grant seen %b required none", stray); end
   endtask

   task automatic test_random();
      int mlast, frames, e, bad_grant, bad_stable, bad_done;
      bit granted;
      logic [3:0] rq_edge, gsave;
      logic [31:0] dat_edge;
      logic [7:0] latched;
      do_reset();
      mlast = NUM_REQ - 1; frames = 0; granted = 1'b0;
      bad_grant = 0; bad_stable = 0; bad_done = 0; gsave = '0; latched = '0;
      for (int i = 0; i < 6000 && frames < 25; i++) begin
         rq_edge = i_req; dat_edge = i_req_data;
         tm_delay = $urandom_range(3, 20);
         tm_hold = $urandom_range(8, 30);
         tick();
         if (!granted && o_grant != 4'b0) begin
            e = rr_model(rq_edge, mlast);
            if (e < 0 || o_grant !== 4'(1 << e) || o_tx_byte !== dat_edge[e*8 +: 8]) begin
               bad_grant++;
               $display("FAIL rand_grant: req=%b last=%0d grant=%b byte=%h required idx %0d", rq_edge, mlast, o_grant, o_tx_byte, e);
            end
            if (e >= 0) mlast = e;
            granted = 1'b1; gsave = o_grant; latched = o_tx_byte;
         end else if (granted) begin
            if (o_tx_byte !== latched || o_grant !== gsave) bad_stable++;
         end
         if (o_done != 4'b0) begin
            if (!granted || o_done !== gsave || o_tx_err !== 1'b0) begin
               bad_done++;
               $display("FAIL rand_done: done=%b err=%b required %b/0", o_done, o_tx_err, gsave);
            end
            granted = 1'b0; frames++;
         end
         i_req = 4'($urandom_range(0, 15));
         i_req_data = $urandom;
      end
      tests++;
      if (bad_grant != 0) fails++;
      tests++;
      if (bad_stable != 0) begin fails++; $display("FAIL rand_stable: %0d cycles with grant/byte changed, required 0", bad_stable); end
      tests++;
      if (bad_done != 0 || frames != 25) begin fails++; $display("FAIL rand_frames: frames=%0d bad_done=%0d required 25/0", frames, bad_done); end
      i_req = 4'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_timeout();
      test_reset_mid();
      test_req_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
